// File: rtl/seg_pkg.sv
// seg_pkg: register address codes and segment patterns shared by the
// seven-segment display controller and its hex decoder.
package seg_pkg;

    localparam logic [1:0] SEG_ADDR_LO   = 2'b00;
    localparam logic [1:0] SEG_ADDR_HI   = 2'b01;
    localparam logic [1:0] SEG_ADDR_CTRL = 2'b10;
    localparam logic [1:0] SEG_ADDR_RSVD = 2'b11;

    // All segments and the decimal point off (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low patterns for hex digits 0..F; bits 0..6 = a..g, bit 7 = dp.
    // Every entry keeps bit 7 set so the decimal point is never lit.
    localparam logic [7:0] SEG_PATTERN [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [7:0] o_seg
);

    assign o_seg = SEG_PATTERN[i_hex];

endmodule

// File: rtl/seg_display.sv
// seg_display: eight-digit multiplexed seven-segment display controller with
// a small CPU-writable register block (data low/high halfwords, digit mask).
// Optional feature: define SEG_BLINK_EN to add a blink control bit that
// blanks the display on alternating groups of BLINK_DIV full scans.
module seg_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SegCtrl,
    input  logic        ioWrite,
    input  logic [1:0]  segAddr,
    input  logic [15:0] write_data,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      r_data;
    logic [7:0]       r_mask;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;

    logic       w_wr;
    logic       w_tc;
    logic [3:0] w_nibble;
    logic [7:0] w_seg;
    logic       w_blank;
    logic       w_digit_on;

    assign w_wr     = SegCtrl & ioWrite;
    assign w_tc     = (r_cnt == CNT_LAST);
    assign w_nibble = r_data[{r_idx, 2'b00} +: 4];

    // Register block: data halfwords and digit mask, written only on a
    // qualified store; reserved address is silently ignored.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_data <= 32'h0;
            r_mask <= 8'hFF;
        end else if (w_wr) begin
            case (segAddr)
                SEG_ADDR_LO:   r_data[15:0]  <= write_data;
                SEG_ADDR_HI:   r_data[31:16] <= write_data;
                SEG_ADDR_CTRL: r_mask        <= write_data[7:0];
                SEG_ADDR_RSVD: ;
                default:       ;
            endcase
        end
    end

    // Scan timer: count SCAN_DIV cycles per digit, then step to the next digit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int WC_W = $clog2(BLINK_DIV + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(BLINK_DIV - 1);

    logic            r_blink;
    logic            r_phase;
    logic [WC_W-1:0] r_wrap_cnt;
    logic            w_wrap;

    assign w_wrap  = w_tc & (r_idx == 3'd7);
    assign w_blank = r_blink & r_phase;

    // Blink enable lives in bit 8 of the control register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_blink <= 1'b0;
        end else if (w_wr && (segAddr == SEG_ADDR_CTRL)) begin
            r_blink <= write_data[8];
        end
    end

    // Blink phase flips once every BLINK_DIV complete scans (digit 7 -> 0).
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wrap_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (w_wrap) begin
            if (r_wrap_cnt == WC_LAST) begin
                r_wrap_cnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_wrap_cnt <= r_wrap_cnt + 1'b1;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_digit_on = r_mask[r_idx] & ~w_blank;

    hex_to_seg u_hex_to_seg (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    // Registered drivers: computed from current index/data/mask so a register
    // write shows up one edge later; masked or blinked digits go fully dark.
    always_ff @(posedge clock) begin
        if (!reset) begin
            seg_en  <= SEG_BLANK;
            seg_out <= SEG_BLANK;
        end else if (w_digit_on) begin
            seg_en  <= ~(8'b1 << r_idx);
            seg_out <= w_seg;
        end else begin
            seg_en  <= SEG_BLANK;
            seg_out <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: directed, table-driven bench for seg_display with
// SCAN_DIV=4 and BLINK_DIV=2. Blink checks follow SEG_BLINK_EN.
module tb_seg_display;

    logic        clock;
    logic        reset;
    logic        SegCtrl;
    logic        ioWrite;
    logic [1:0]  segAddr;
    logic [15:0] write_data;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;   // rising edges since reset was last released

    typedef struct {
        logic [7:0] en;
        logic [7:0] out;
    } vec_t;

    vec_t tab_abcd1234 [8];

    seg_display #(
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .SegCtrl    (SegCtrl),
        .ioWrite    (ioWrite),
        .segAddr    (segAddr),
        .write_data (write_data),
        .seg_en     (seg_en),
        .seg_out    (seg_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        k++;
        @(negedge clock);
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic check(input string name, input logic [7:0] en_exp, input logic [7:0] out_exp);
        n_cmp++;
        if (seg_en !== en_exp || seg_out !== out_exp) begin
            n_err++;
            $display("FAIL %s at k=%0d: seg_en=%h seg_out=%h, expected seg_en=%h seg_out=%h",
                     name, k, seg_en, seg_out, en_exp, out_exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        SegCtrl    = 1'b1;
        ioWrite    = 1'b1;
        segAddr    = a;
        write_data = d;
        tick();
        SegCtrl    = 1'b0;
        ioWrite    = 1'b0;
    endtask

    initial begin
        // Display 0xABCD1234: digit i shows nibble i.
        tab_abcd1234[0] = '{8'hFE, 8'h99};  // 4
        tab_abcd1234[1] = '{8'hFD, 8'hB0};  // 3
        tab_abcd1234[2] = '{8'hFB, 8'hA4};  // 2
        tab_abcd1234[3] = '{8'hF7, 8'hF9};  // 1
        tab_abcd1234[4] = '{8'hEF, 8'hA1};  // d
        tab_abcd1234[5] = '{8'hDF, 8'hC6};  // C
        tab_abcd1234[6] = '{8'hBF, 8'h83};  // b
        tab_abcd1234[7] = '{8'h7F, 8'h88};  // A

        reset      = 1'b0;
        SegCtrl    = 1'b0;
        ioWrite    = 1'b0;
        segAddr    = 2'b00;
        write_data = 16'h0000;
        @(negedge clock);

        // Reset held for three edges, then first digit.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", 8'hFF, 8'hFF);
        end
        reset = 1'b1;
        k = 0;
        tick();
        check("first_digit", 8'hFE, 8'hC0);

        // Data display.
        wr(2'b00, 16'h1234);
        wr(2'b01, 16'hABCD);
        run_to(32);
        for (int d = 0; d < 8; d++)
            for (int c = 0; c < 4; c++) begin
                tick();
                check("scan_data", tab_abcd1234[d].en, tab_abcd1234[d].out);
            end

        // Write gating: no select, reserved address, no strobe.
        SegCtrl = 1'b0; ioWrite = 1'b1; segAddr = 2'b00; write_data = 16'hFFFF;
        tick();
        SegCtrl = 1'b1; ioWrite = 1'b1; segAddr = 2'b11;
        tick();
        SegCtrl = 1'b1; ioWrite = 1'b0; segAddr = 2'b00;
        tick();
        SegCtrl = 1'b0;
        run_to(96);
        for (int d = 0; d < 8; d++)
            for (int c = 0; c < 4; c++) begin
                tick();
                check("gated_write", tab_abcd1234[d].en, tab_abcd1234[d].out);
            end

        // Mask 0F: digits 4-7 dark, wrap back to digit 0 after 32 cycles.
        wr(2'b10, 16'h000F);
        run_to(160);
        for (int d = 0; d < 8; d++)
            for (int c = 0; c < 4; c++) begin
                tick();
                if (d < 4) check("mask_on", tab_abcd1234[d].en, tab_abcd1234[d].out);
                else       check("mask_off", 8'hFF, 8'hFF);
            end
        tick();
        check("mask_wrap", 8'hFE, 8'h99);

        // Write on the same edge as a digit advance.
        wr(2'b10, 16'h00FF);
        run_to(195);
        SegCtrl = 1'b1; ioWrite = 1'b1; segAddr = 2'b00; write_data = 16'h5678;
        tick();
        check("pre_write_vis", 8'hFE, 8'h99);
        SegCtrl = 1'b0; ioWrite = 1'b0;
        tick();
        check("write_advance", 8'hFD, 8'hF8);

        // Mid-scan reset at index 5, count 2 (mask 7F to prove mask reset).
        run_to(200);
        wr(2'b10, 16'h007F);
        run_to(246);
        check("pre_reset_d5", 8'hDF, 8'hC6);
        reset = 1'b0;
        tick();
        check("mid_reset", 8'hFF, 8'hFF);
        reset = 1'b1;
        k = 0;
        tick();
        check("post_reset_d0", 8'hFE, 8'hC0);
        run_to(5);
        check("post_reset_d1", 8'hFD, 8'hC0);
        run_to(29);
        check("post_reset_mask", 8'h7F, 8'hC0);

        // Blink control write (bit 8 ignored without SEG_BLINK_EN).
        run_to(40);
        wr(2'b10, 16'h01FF);
        run_to(64);
        check("blink_on_end", 8'h7F, 8'hC0);
        tick();
`ifdef SEG_BLINK_EN
        check("blink_off_start", 8'hFF, 8'hFF);
        run_to(128);
        check("blink_off_end", 8'hFF, 8'hFF);
`else
        check("noblink_65", 8'hFE, 8'hC0);
        run_to(128);
        check("noblink_128", 8'h7F, 8'hC0);
`endif
        tick();
        check("blink_on_again", 8'hFE, 8'hC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
